// File: rtl/mips_mc_pkg.sv
// Shared opcode/funct constants, ALU and FSM enums for the multi-cycle MIPS core.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;
  localparam logic [5:0] FN_JR  = 6'd8;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  function automatic logic [31:0] alu(alu_op_e op, logic [31:0] x, logic [31:0] y);
    case (op)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return {31'd0, $signed(x) < $signed(y)};
      default: return x + y;
    endcase
  endfunction

  function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
    case (op)
      OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR};
      OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_reg_file.sv
// 32x32 register file: two combinational read ports, one write port, r0 hardwired to zero.
module mc_reg_file
  import mips_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0][31:0] regs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-32 core sharing one handshaked memory port for fetch and data.
// Define MIPS_MC_TRAP_EN to halt with a sticky trap on unknown instructions.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [31:0]       pc_o,
  output logic [31:0]       instr_o,
  output logic              trap
);

  state_e      state, state_n;
  logic [31:0] pc, pc_n, ir, a, b, imm, alu_out, mdr;
  logic [31:0] rd1, rd2, rf_wd, alu_b, alu_y, addr_full;
  logic [4:0]  rf_wa;
  logic [5:0]  op, fn;
  logic        rf_we, ir_ld, mdr_ld;
  alu_op_e     alu_op;
`ifdef MIPS_MC_TRAP_EN
  logic        trap_set, trap_q;
`endif

  assign op = ir[31:26];
  assign fn = ir[5:0];

  mc_reg_file u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (ir[25:21]),
    .ra2 (ir[20:16]),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_comb begin
    alu_op = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (op == OP_SLTI) begin
      alu_op = ALU_SLT;
    end
  end

  assign alu_b = (op == OP_RTYPE) ? b : imm;
  assign alu_y = alu(alu_op, a, alu_b);

  // Word alignment is enforced here rather than trapping on misaligned addresses.
  assign addr_full = ((state == S_FETCH) ? pc : alu_out) & ~32'h3;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b;
  assign pc_o      = pc;
  assign instr_o   = ir;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_ld   = 1'b0;
    mdr_ld  = 1'b0;
    rf_we   = 1'b0;
    rf_wa   = (op == OP_RTYPE) ? ir[15:11] : ir[20:16];
    rf_wd   = (op == OP_LW) ? mdr : alu_out;
    retire  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
`ifdef MIPS_MC_TRAP_EN
    trap_set = 1'b0;
`endif
    case (state)
      S_BOOT: state_n = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_ld   = 1'b1;
          pc_n    = pc + 32'd4;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_J || op == OP_JAL) begin
          pc_n    = {pc[31:28], ir[25:0], 2'b00};
          retire  = 1'b1;
          state_n = S_FETCH;
          if (op == OP_JAL) begin
            rf_we = 1'b1;
            rf_wa = 5'd31;
            rf_wd = pc;
          end
        end else if (op == OP_RTYPE && fn == FN_JR) begin
          pc_n    = rd1;
          retire  = 1'b1;
          state_n = S_FETCH;
        end else if (!is_legal(op, fn)) begin
`ifdef MIPS_MC_TRAP_EN
          trap_set = 1'b1;
          state_n  = S_HALT;
`else
          retire  = 1'b1;
          state_n = S_FETCH;
`endif
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_BEQ) begin
          if (a == b) pc_n = pc + {imm[29:0], 2'b00};
          retire  = 1'b1;
          state_n = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_n = S_MEM;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_SW);
        if (mem_ready) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            state_n = S_FETCH;
          end else begin
            mdr_ld  = 1'b1;
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_BOOT;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (ir_ld)  ir  <= mem_rdata;
      if (mdr_ld) mdr <= mem_rdata;
      if (state == S_DECODE) begin
        a   <= rd1;
        b   <= rd2;
        imm <= {{16{ir[15]}}, ir[15:0]};
      end
      if (state == S_EXEC) alu_out <= alu_y;
    end
  end

`ifdef MIPS_MC_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trap_q <= 1'b0;
    else if (trap_set) trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// Random-program bench: an instruction-level model predicts retires, next PCs, stores and cycle counts.
`timescale 1ns/1ps
module tb_mips_mc_core;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int MW = 512, NPROG = 150, NINS = 400;

  logic        clk = 1'b0, rst = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o, instr_o;
  logic [31:0] mem [MW];

  typedef struct { logic [31:0] instr; logic [31:0] npc; int base; } ret_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  ret_t ret_q[$];
  st_t  st_q[$];
  int   checks = 0, failures = 0, ready_pct = 100;
  bit   run = 1'b0;

  mips_mc_core #(.RESET_PC(RESET_PC), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .pc_o(pc_o), .instr_o(instr_o), .trap(trap)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[10:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic gen_prog();
    logic [5:0] fns [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    for (int i = 0; i < MW; i++) mem[i] = $urandom;
    mem[0] = enc_i(8, 0, 1, 5);
    for (int i = 1; i < NPROG; i++) begin
      int k   = $urandom_range(0, 11);
      int rs  = $urandom_range(0, 7);
      int rt  = $urandom_range(0, 7);
      int rd  = $urandom_range(0, 7);
      int tgt = i + 1 + $urandom_range(0, 3);
      int dof = 'h400 + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);
      if (tgt > NPROG) tgt = NPROG;
      case (k)
        0, 1, 2, 3: mem[i] = enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
        4:  mem[i] = enc_i(8, rs, rd, $urandom);
        5:  mem[i] = enc_i(8, rs, rd, $urandom_range(0, 40) - 20);
        6:  mem[i] = enc_i(10, rs, rd, $urandom);
        7:  mem[i] = enc_i(35, 0, rd, dof);
        8:  mem[i] = enc_i(43, 0, ($urandom_range(0, 8) == 8) ? 31 : rt, dof);
        9:  mem[i] = enc_i(4, rs, ($urandom_range(0, 1) == 1) ? rs : rt, tgt - i - 1);
        10: mem[i] = {(($urandom_range(0, 1) == 1) ? 6'd3 : 6'd2), tgt[25:0]};
        default: begin
`ifdef MIPS_MC_TRAP_EN
          mem[i] = enc_r(31, 0, 0, 6'd8);
`else
          case ($urandom_range(0, 2))
            0: mem[i] = enc_r(31, 0, 0, 6'd8);
            1: mem[i] = enc_r(rs, rt, rd, 6'd0);
            default: mem[i] = {6'h3F, 26'($urandom)};
          endcase
`endif
        end
      endcase
    end
    mem[NPROG] = 32'h1000_FFFF;
  endtask

  // Architectural model: runs NINS instructions and queues what the core must show.
  task automatic iss_run();
    logic [31:0] r [32];
    logic [31:0] dm [MW];
    logic [31:0] pc, ins, npc, sx, ea, wv;
    int wr, base, rs, rt;
    ret_t e;
    st_t  s;
    dm = mem;
    pc = RESET_PC;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    for (int n = 0; n < NINS; n++) begin
      ins = dm[pc[10:2]];
      sx  = {{16{ins[15]}}, ins[15:0]};
      rs  = ins[25:21];
      rt  = ins[20:16];
      npc = pc + 4; wr = 0; wv = 0; base = 2;
      case (ins[31:26])
        6'd0: begin
          base = 4; wr = ins[15:11];
          case (ins[5:0])
            6'd32: wv = r[rs] + r[rt];
            6'd34: wv = r[rs] - r[rt];
            6'd36: wv = r[rs] & r[rt];
            6'd37: wv = r[rs] | r[rt];
            6'd42: wv = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
            6'd8:  begin npc = r[rs]; base = 2; wr = 0; end
            default: begin base = 2; wr = 0; end
          endcase
        end
        6'd2, 6'd3: begin
          npc = {npc[31:28], ins[25:0], 2'b00};
          if (ins[31:26] == 6'd3) begin wr = 31; wv = pc + 4; end
        end
        6'd4:  begin base = 3; if (r[rs] == r[rt]) npc = pc + 4 + (sx << 2); end
        6'd8:  begin base = 4; wr = rt; wv = r[rs] + sx; end
        6'd10: begin base = 4; wr = rt; wv = ($signed(r[rs]) < $signed(sx)) ? 32'd1 : 32'd0; end
        6'd35: begin base = 5; ea = (r[rs] + sx) & ~32'h3; wr = rt; wv = dm[ea[10:2]]; end
        6'd43: begin
          base = 4; ea = (r[rs] + sx) & ~32'h3;
          dm[ea[10:2]] = r[rt];
          s.addr = ea; s.data = r[rt];
          st_q.push_back(s);
        end
        default: ;
      endcase
      if (wr != 0) r[wr] = wv;
      e.instr = ins; e.npc = npc; e.base = base;
      ret_q.push_back(e);
      pc = npc;
    end
  endtask

  // Memory: ready randomised after each rising edge; stores land when accepted.
  initial forever begin
    @(posedge clk);
    #1 mem_ready = ($urandom_range(0, 99) < ready_pct);
  end

  initial forever begin
    @(negedge clk);
    if (rst && mem_req && mem_we && mem_ready) mem[mem_addr[10:2]] = mem_wdata;
  end

  initial begin
    int cyc = -1, waits = 0;
    bit chk_pc = 1'b0, stall = 1'b0, p_we = 1'b0;
    logic [31:0] exp_pc = 0, p_addr = 0, p_wdata = 0;
    ret_t e;
    st_t  s;
    forever begin
      @(negedge clk);
      if (!rst || !run) begin
        cyc = -1; waits = 0; chk_pc = 1'b0; stall = 1'b0;
      end else begin
        if (chk_pc) check("next_pc", pc_o, exp_pc);
        chk_pc = 1'b0;
        cyc++;
        if (mem_req && !mem_ready) waits++;
        if (stall) check("req_hold", {mem_req, mem_we, mem_addr[29:0]}, {2'b10 | {1'b0, p_we}, p_addr[29:0]});
        if (stall) check("wdata_hold", mem_wdata, p_wdata);
        stall = mem_req && !mem_ready;
        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        if (mem_req && mem_we && mem_ready && st_q.size() > 0) begin
          s = st_q.pop_front();
          check("store_addr", mem_addr, s.addr);
          check("store_data", mem_wdata, s.data);
        end
        if (retire) begin
          if (ret_q.size() > 0) begin
            e = ret_q.pop_front();
            check("retire_instr", instr_o, e.instr);
            check("instr_cycles", cyc - waits, e.base);
            exp_pc = e.npc;
            chk_pc = 1'b1;
          end
          cyc = 0; waits = 0;
        end
      end
    end
  end

  initial begin
    bit seen = 1'b0;
    gen_prog();
    iss_run();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_retire", retire, 0);
    check("rst_trap", trap, 0);
    check("rst_pc", pc_o, RESET_PC);
    check("rst_ir", instr_o, 0);
    run = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("boot_no_req", mem_req, 0);
    @(negedge clk);
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, RESET_PC);
    for (int c = 0; c < 20000 && ret_q.size() > 0; c++) begin
      @(negedge clk);
      if (ret_q.size() < NINS / 2) ready_pct = 60;
    end
    repeat (2) @(negedge clk);
    check("retire_drain", ret_q.size(), 0);
    check("store_drain", st_q.size(), 0);
    check("trap_clear", trap, 0);
    // Stall a fetch, then pull reset between edges: the request must vanish at once.
    run = 1'b0;
    ready_pct = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = mem_req && !mem_we && !mem_ready;
    end
    check("fetch_stalled", seen, 1);
    #2 rst = 1'b0;
    #1;
    check("midreq_req_drop", mem_req, 0);
    check("midreq_pc", pc_o, RESET_PC);
    check("midreq_ir", instr_o, 0);
    check("midreq_retire", retire, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
